// File: rtl/gpr_wb_arbiter_rr_if.sv
// CR0/XER side-result type and the producer/consumer bundle of the GPR write-back arbiter.
// master = producers + consumer (the environment), slave = the arbiter.
package gpr_wb_pkg;
  typedef struct packed {
    logic [3:0] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;
endpackage

interface gpr_wb_arbiter_rr_if #(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_UNITS   = 4
);
  import gpr_wb_pkg::*;
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [0:NUM_UNITS-1]   input_valid;
  logic [0:NUM_UNITS-1]   input_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_in           [NUM_UNITS];
  logic [4:0]             result_reg_addr_in [NUM_UNITS];
  logic [31:0]            result_in          [NUM_UNITS];
  cond_exception_t        cr0_xer_in         [NUM_UNITS];

  logic                   output_valid;
  logic                   output_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_out;
  logic [4:0]             result_reg_addr_out;
  logic [31:0]            result_out;
  cond_exception_t        cr0_xer_out;
  logic [PTR_W-1:0]       grant_ptr;

  modport master (
    output input_valid, rs_id_in, result_reg_addr_in, result_in, cr0_xer_in, output_ready,
    input  input_ready, output_valid, rs_id_out, result_reg_addr_out, result_out, cr0_xer_out,
           grant_ptr
  );

  modport slave (
    input  input_valid, rs_id_in, result_reg_addr_in, result_in, cr0_xer_in, output_ready,
    output input_ready, output_valid, rs_id_out, result_reg_addr_out, result_out, cr0_xer_out,
           grant_ptr
  );
endinterface

// File: rtl/gpr_wb_arbiter_rr.sv
// GPR write-back arbiter: picks one valid producer per cycle (round-robin or fixed priority)
// and registers it into a single output slot with full-throughput back-pressure.
module gpr_wb_arbiter_rr
  import gpr_wb_pkg::*;
#(
  parameter int RS_ID_WIDTH   = 5,
  parameter int NUM_UNITS     = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  gpr_wb_arbiter_rr_if.slave   bus
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_UNITS - 1);

  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       winner;
  logic                   win_valid;
  logic                   slot_free;
  logic                   xfer;
  int                     idx;

  logic                   out_valid;
  logic [RS_ID_WIDTH-1:0] out_rs_id;
  logic [4:0]             out_addr;
  logic [31:0]            out_result;
  cond_exception_t        out_cx;

  // Scan from the far end so the first valid unit in priority order is the last one written.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      idx = ((PRIORITY_MODE != 0) ? 0 : int'(ptr)) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      if (bus.input_valid[idx]) begin
        winner    = PTR_W'(idx);
        win_valid = 1'b1;
      end
    end
  end

  assign slot_free = !out_valid || bus.output_ready;
  assign xfer      = rst && slot_free && win_valid;

  always_comb begin
    bus.input_ready = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      bus.input_ready[i] = xfer && (winner == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_rs_id  <= '0;
      out_addr   <= '0;
      out_result <= '0;
      out_cx     <= '0;
      ptr        <= '0;
    end else begin
      if (xfer) begin
        out_valid  <= 1'b1;
        out_rs_id  <= bus.rs_id_in[winner];
        out_addr   <= bus.result_reg_addr_in[winner];
        out_result <= bus.result_in[winner];
        out_cx     <= bus.cr0_xer_in[winner];
      end else if (bus.output_ready) begin
        out_valid  <= 1'b0;
      end
      if (xfer && (PRIORITY_MODE == 0)) begin
        ptr <= (winner == LAST) ? '0 : winner + PTR_W'(1);
      end
    end
  end

  assign bus.output_valid        = out_valid;
  assign bus.rs_id_out           = out_rs_id;
  assign bus.result_reg_addr_out = out_addr;
  assign bus.result_out          = out_result;
  assign bus.cr0_xer_out         = out_cx;
  assign bus.grant_ptr           = ptr;
endmodule

// File: tb/tb_gpr_wb_arbiter_rr.sv
// Scoreboard bench for gpr_wb_arbiter_rr: a reference model predicts grants and queues the
// expected results, a separate monitor pops and compares whatever the DUT presents.
module tb_gpr_wb_arbiter_rr;
  import gpr_wb_pkg::*;
  localparam int N  = 4;
  localparam int RW = 5;

  typedef struct {
    int               unit;
    logic [RW-1:0]    rs;
    logic [4:0]       addr;
    logic [31:0]      res;
    cond_exception_t  cx;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_arbiter_rr_if #(.RS_ID_WIDTH(RW), .NUM_UNITS(N)) bus ();
  gpr_wb_arbiter_rr_if #(.RS_ID_WIDTH(RW), .NUM_UNITS(N)) bus_fx ();

  gpr_wb_arbiter_rr #(.RS_ID_WIDTH(RW), .NUM_UNITS(N), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  gpr_wb_arbiter_rr #(.RS_ID_WIDTH(RW), .NUM_UNITS(N), .PRIORITY_MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .bus(bus_fx));

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: arbitration rules stated directly as a modular scan.
  int    m_ptr = 0;
  bit    m_ov  = 0;
  item_t sbq[$];

  function automatic int rr_pick(logic [0:N-1] v, int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    bit sf;
    logic [0:N-1] exp_rdy;
    item_t it;
    if (!rst) begin
      m_ptr = 0;
      m_ov  = 0;
      sbq.delete();
      check("rst_output_valid", bus.output_valid, 0);
      check("rst_input_ready", bus.input_ready, 0);
      check("rst_grant_ptr", bus.grant_ptr, 0);
    end else begin
      check("output_valid", bus.output_valid, m_ov);
      check("grant_ptr", bus.grant_ptr, m_ptr);
      sf = !m_ov || bus.output_ready;
      w  = rr_pick(bus.input_valid, m_ptr);
      exp_rdy = '0;
      if (sf && w >= 0) exp_rdy[w] = 1'b1;
      check("input_ready", bus.input_ready, exp_rdy);
      if (sf && w >= 0) begin
        it.unit = w;
        it.rs   = bus.rs_id_in[w];
        it.addr = bus.result_reg_addr_in[w];
        it.res  = bus.result_in[w];
        it.cx   = bus.cr0_xer_in[w];
        sbq.push_back(it);
        m_ptr = (w == N - 1) ? 0 : w + 1;
        m_ov  = 1;
      end else if (m_ov && bus.output_ready) begin
        m_ov = 0;
      end
    end
  end

  // Monitor: every cycle the output is valid it must show the queue head; pop on acceptance.
  always @(negedge clk) begin
    item_t e;
    if (rst && bus.output_valid) begin
      check("sb_not_empty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq[0];
        check("rs_id_out", bus.rs_id_out, e.rs);
        check("result_reg_addr_out", bus.result_reg_addr_out, e.addr);
        check("result_out", bus.result_out, e.res);
        check("cr0_xer_out", bus.cr0_xer_out, e.cx);
        if (bus.output_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic set_unit(int u, logic [RW-1:0] rs, logic [4:0] a, logic [31:0] r,
                          cond_exception_t cx);
    bus.input_valid[u]        = 1'b1;
    bus.rs_id_in[u]           = rs;
    bus.result_reg_addr_in[u] = a;
    bus.result_in[u]          = r;
    bus.cr0_xer_in[u]         = cx;
  endtask

  task automatic set_rand(int u);
    set_unit(u, RW'($urandom), 5'($urandom), $urandom, cond_exception_t'($urandom));
  endtask

  task automatic step(output logic [0:N-1] taken);
    @(negedge clk);
    taken = bus.input_valid & bus.input_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic int first_set(logic [0:N-1] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [0:N-1] taken;
  logic [0:N-1] fx_exp;
  int           exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    bus.output_ready    = 1'b1;
    bus_fx.output_ready = 1'b1;
    bus_fx.input_valid  = '0;
    for (int u = 0; u < N; u++) begin
      set_rand(u);
      bus_fx.rs_id_in[u]           = RW'(u);
      bus_fx.result_reg_addr_in[u] = 5'(u + 8);
      bus_fx.result_in[u]          = 32'h1111_0000 * (u + 1) + u;
      bus_fx.cr0_xer_in[u]         = cond_exception_t'(u);
    end

    // Reset held with every unit valid.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready_all_valid", bus.input_ready, 0);
    bus.input_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Single transfer from unit 2.
    set_unit(2, 5'd3, 5'd5, 32'hDEADBEEF, cond_exception_t'(7'h15));
    step(taken);
    check("single_taken", taken, 4'b0010);
    bus.input_valid[2] = 1'b0;
    @(negedge clk);
    check("single_valid", bus.output_valid, 1);
    check("single_result", bus.result_out, 32'hDEADBEEF);
    check("single_addr", bus.result_reg_addr_out, 5);
    check("single_rs_id", bus.rs_id_out, 3);
    check("single_ptr", bus.grant_ptr, 3);
    @(posedge clk); #1;

    // Restart from pointer 0, then all units valid.
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int u = 0; u < N; u++) set_rand(u);
    for (int i = 0; i < 6; i++) begin
      step(taken);
      check("rr_order", first_set(taken), exp_order[i]);
      set_rand(first_set(taken) < 0 ? 0 : first_set(taken));
    end

    // Back-pressure for three cycles, then release with no bubble.
    bus.output_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(taken);
      check("stall_no_grant", taken, 0);
    end
    bus.output_ready = 1'b1;
    step(taken);
    check("release_unit", first_set(taken), 2);
    set_rand(2);

    // Reset while stalled.
    bus.output_ready = 1'b0;
    step(taken);
    #2 rst = 1'b0;
    #1;
    check("midstall_valid", bus.output_valid, 0);
    check("midstall_ptr", bus.grant_ptr, 0);
    check("midstall_ready", bus.input_ready, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.output_ready = 1'b1;
    step(taken);
    check("after_reset_unit", first_set(taken), 0);
    set_rand(0);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < N; u++) begin
        if (taken[u] || !bus.input_valid[u]) begin
          if ($urandom_range(0, 99) < 55) set_rand(u);
          else bus.input_valid[u] = 1'b0;
        end
      end
      bus.output_ready = ($urandom_range(0, 3) != 0);
      step(taken);
    end

    bus.input_valid  = '0;
    bus.output_ready = 1'b1;
    repeat (3) step(taken);
    check("drain_empty", sbq.size(), 0);

    // Fixed-priority instance: units 0 and 1 always valid.
    bus_fx.input_valid[0] = 1'b1;
    bus_fx.input_valid[1] = 1'b1;
    fx_exp = '0;
    fx_exp[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fx_ready_unit0", bus_fx.input_ready, fx_exp);
      check("fx_ptr", bus_fx.grant_ptr, 0);
      if (i > 0) check("fx_result_unit0", bus_fx.result_out, 32'h1111_0000);
      @(posedge clk); #1;
    end
    bus_fx.input_valid[0] = 1'b0;
    fx_exp = '0;
    fx_exp[1] = 1'b1;
    @(negedge clk);
    check("fx_ready_unit1", bus_fx.input_ready, fx_exp);
    @(posedge clk); #1;
    @(negedge clk);
    check("fx_result_unit1", bus_fx.result_out, 32'h2222_0001);
    check("fx_rs_unit1", bus_fx.rs_id_out, 1);
    check("fx_valid", bus_fx.output_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
